instr_cache: RTL and testbench

INSTR_CACHE -- requirements
Module: instr_cache

---
 rtl/instr_cache_if.sv | 26 ++
 rtl/instr_cache.sv | 114 +++++++++++
 tb/tb_instr_cache.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_cache_if.sv
// Fetch-stage and refill-memory signal bundle for instr_cache.
// The cache takes the slave view; the fetch stage and memory side together take the master view.
interface instr_cache_if;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache with zero-latency hits and block refill.
// Define ICACHE_PERF_EN to add the 32-bit miss_count output.
module instr_cache #(
  parameter int NUM_SETS    = 8,
  parameter int BLOCK_WORDS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  instr_cache_if.slave bus
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]  miss_count
`endif
);

  localparam int OFF_W  = $clog2(BLOCK_WORDS);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int BLK_W  = 30 - OFF_W;
  localparam int TAG_W  = BLK_W - IDX_W;
  localparam int LINE_W = 32 * BLOCK_WORDS;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t             state, state_next;
  logic [NUM_SETS-1:0] valid;
  logic [TAG_W-1:0]   tag_mem  [NUM_SETS];
  logic [LINE_W-1:0]  data_mem [NUM_SETS];
  logic [BLK_W-1:0]   miss_addr;

  logic [OFF_W-1:0]   req_off;
  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic [IDX_W-1:0]   fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic [LINE_W-1:0]  req_line;
  logic               hit;
  logic               miss_start;
  logic               fill;

  assign req_off  = bus.proc_addr[OFF_W-1:0];
  assign req_idx  = bus.proc_addr[OFF_W +: IDX_W];
  assign req_tag  = bus.proc_addr[29 -: TAG_W];
  assign fill_idx = miss_addr[IDX_W-1:0];
  assign fill_tag = miss_addr[BLK_W-1 -: TAG_W];
  assign req_line = data_mem[req_idx];
  assign hit      = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign fill     = (state == FETCH) && bus.mem_ready;

  // The memory side is read-only; the write channel is tied off.
  assign bus.mem_write = 1'b0;
  assign bus.mem_wdata = '0;
  assign bus.mem_addr  = miss_addr;

  // The pipeline never writes instruction memory, so these inputs are sunk here.
  logic unused_inputs;
  assign unused_inputs = ^{bus.proc_write, bus.proc_wdata};

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next     = state;
    bus.proc_stall = 1'b0;
    bus.proc_rdata = '0;
    bus.mem_read   = 1'b0;
    miss_start     = 1'b0;
    case (state)
      IDLE: begin
        // rst_n gates the lookup so reset shows no stall even with a request pending.
        if (rst_n && bus.proc_read) begin
          if (hit) begin
            bus.proc_rdata = req_line[{req_off, 5'd0} +: 32];
          end else begin
            bus.proc_stall = 1'b1;
            miss_start     = 1'b1;
            state_next     = FETCH;
          end
        end
      end
      FETCH: begin
        bus.proc_stall = 1'b1;
        bus.mem_read   = 1'b1;
        if (bus.mem_ready) state_next = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      valid     <= '0;
      miss_addr <= '0;
    end else begin
      state <= state_next;
      if (miss_start) miss_addr <= bus.proc_addr[29:OFF_W];
      if (fill)       valid[fill_idx] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays carry no reset; the valid bits alone make stale contents harmless.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= bus.mem_rdata;
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          miss_count <= '0;
    else if (miss_start) miss_count <= miss_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_instr_cache.sv
// Self-checking bench for instr_cache: directed scenarios plus random fetches scored
// against a block-address reference model of a direct-mapped cache.
module tb_instr_cache;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  instr_cache_if bus();
`ifdef ICACHE_PERF_EN
  logic [31:0] miss_count;
`endif

  instr_cache #(.NUM_SETS(8), .BLOCK_WORDS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ICACHE_PERF_EN
    ,
    .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: which block address each set holds, and its contents.
  logic         m_valid [8];
  logic [27:0]  m_blk   [8];
  logic [127:0] m_data  [8];
  int           m_misses;

  function automatic logic [31:0] m_word(input logic [29:0] a);
    logic [127:0] d;
    d = m_data[a[4:2]];
    return d[int'(a[1:0]) * 32 +: 32];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    m_misses = 0;
  endtask

  // One fetch of addr: predicts hit/miss from the model, serves a miss with blk after lat cycles.
  task automatic access(input logic [29:0] addr, input int lat, input logic [127:0] blk);
    logic exp_hit;
    int   idx;
    idx     = int'(addr[4:2]);
    exp_hit = m_valid[idx] && (m_blk[idx] == addr[29:2]);
    bus.mem_ready = 1'b0;
    bus.proc_read = 1'b1;
    bus.proc_addr = addr;
    @(negedge clk);
    total++;
    if (bus.proc_stall !== !exp_hit) begin
      bad++;
      $display("FAIL lookup_stall addr=%h got=%b want=%b", addr, bus.proc_stall, !exp_hit);
    end
    if (exp_hit) begin
      total++;
      if (bus.proc_rdata !== m_word(addr) || bus.mem_read !== 1'b0) begin
        bad++;
        $display("FAIL hit_data addr=%h got=%h/%b want=%h/0", addr, bus.proc_rdata, bus.mem_read, m_word(addr));
      end
    end else begin
      m_misses++;
      for (int c = 0; c < lat; c++) begin
        @(posedge clk); #1;
        if (c == lat - 1) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = blk;
        end
        @(negedge clk);
        total++;
        if (bus.mem_read !== 1'b1 || bus.mem_addr !== addr[29:2] || bus.proc_stall !== 1'b1) begin
          bad++;
          $display("FAIL fetch_hold addr=%h got rd=%b ma=%h st=%b want rd=1 ma=%h st=1",
                   addr, bus.mem_read, bus.mem_addr, bus.proc_stall, addr[29:2]);
        end
      end
      @(posedge clk); #1;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = {4{$urandom}};
      m_valid[idx] = 1'b1;
      m_blk[idx]   = addr[29:2];
      m_data[idx]  = blk;
      @(negedge clk);
      total++;
      if (bus.proc_stall !== 1'b0 || bus.mem_read !== 1'b0 || bus.proc_rdata !== m_word(addr)) begin
        bad++;
        $display("FAIL refill_hit addr=%h got st=%b rd=%b d=%h want st=0 rd=0 d=%h",
                 addr, bus.proc_stall, bus.mem_read, bus.proc_rdata, m_word(addr));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    model_reset();
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'h10;
    repeat (2) @(negedge clk);
    total++;
    if (bus.proc_stall !== 1'b0 || bus.proc_rdata !== 32'h0 || bus.mem_read !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got st=%b d=%h rd=%b want 0/0/0", bus.proc_stall, bus.proc_rdata, bus.mem_read);
    end
    total++;
    if (bus.mem_write !== 1'b0 || bus.mem_wdata !== 128'h0 || bus.mem_addr !== 28'h0) begin
      bad++;
      $display("FAIL reset_mem got mw=%b wd=%h ma=%h want 0/0/0", bus.mem_write, bus.mem_wdata, bus.mem_addr);
    end
`ifdef ICACHE_PERF_EN
    total++;
    if (miss_count !== 32'd0) begin
      bad++;
      $display("FAIL reset_miss_count got=%0d want=0", miss_count);
    end
`endif
    bus.proc_read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.proc_stall !== 1'b0 || bus.mem_read !== 1'b0 || bus.proc_rdata !== 32'h0) begin
      bad++;
      $display("FAIL idle_no_req got st=%b rd=%b d=%h want 0/0/0", bus.proc_stall, bus.mem_read, bus.proc_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_cold_and_hit();
    access(30'h0000010, 5, 128'h44444444_33333333_22222222_11111111);
    bus.proc_addr = 30'h0000013;
    @(negedge clk);
    total++;
    if (bus.proc_stall !== 1'b0 || bus.proc_rdata !== 32'h44444444 || bus.mem_read !== 1'b0) begin
      bad++;
      $display("FAIL same_block_hit got st=%b d=%h rd=%b want 0/44444444/0", bus.proc_stall, bus.proc_rdata, bus.mem_read);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_conflict();
    access(30'h0000030, 3, {$urandom, $urandom, $urandom, $urandom});
    total++;
    if (m_valid[4] !== 1'b1 || m_blk[4] !== 28'hC) begin
      bad++;
      $display("FAIL conflict_model got blk=%h want=00000c", m_blk[4]);
    end
    access(30'h0000010, 4, 128'h44444444_33333333_22222222_11111111);
  endtask

`ifdef ICACHE_PERF_EN
  task automatic test_perf(input int want);
    @(negedge clk);
    total++;
    if (miss_count !== 32'(want)) begin
      bad++;
      $display("FAIL miss_count got=%0d want=%0d", miss_count, want);
    end
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_addr_change();
    logic [127:0] blk;
    blk = {$urandom, $urandom, $urandom, $urandom};
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'h0000054;
    @(negedge clk);
    total++;
    if (bus.proc_stall !== 1'b1) begin
      bad++;
      $display("FAIL chg_miss got st=%b want=1", bus.proc_stall);
    end
    m_misses++;
    @(posedge clk); #1;
    bus.proc_addr = 30'h0000100;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = blk;
      end
      if (c == 1) bus.proc_read = 1'b0;
      @(negedge clk);
      total++;
      if (bus.mem_addr !== 28'h15 || bus.mem_read !== 1'b1 || bus.proc_stall !== 1'b1) begin
        bad++;
        $display("FAIL chg_hold got ma=%h rd=%b st=%b want 15/1/1", bus.mem_addr, bus.mem_read, bus.proc_stall);
      end
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b0;
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'h0000054;
    m_valid[5] = 1'b1;
    m_blk[5]   = 28'h15;
    m_data[5]  = blk;
    @(negedge clk);
    total++;
    if (bus.proc_stall !== 1'b0 || bus.proc_rdata !== blk[31:0]) begin
      bad++;
      $display("FAIL chg_fill_index got st=%b d=%h want 0/%h", bus.proc_stall, bus.proc_rdata, blk[31:0]);
    end
    @(posedge clk); #1;
    access(30'h0000100, 2, {$urandom, $urandom, $urandom, $urandom});
  endtask

  task automatic test_reset_mid_fetch();
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'h0000024;
    @(negedge clk);
    total++;
    if (bus.proc_stall !== 1'b1) begin
      bad++;
      $display("FAIL rst_fetch_miss got st=%b want=1", bus.proc_stall);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.mem_read !== 1'b0 || bus.proc_stall !== 1'b0 || bus.proc_rdata !== 32'h0) begin
      bad++;
      $display("FAIL rst_abort got rd=%b st=%b d=%h want 0/0/0", bus.mem_read, bus.proc_stall, bus.proc_rdata);
    end
    model_reset();
    bus.proc_read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = {4{32'hDEADBEEF}};
    @(negedge clk);
    total++;
    if (bus.mem_read !== 1'b0 || bus.proc_stall !== 1'b0) begin
      bad++;
      $display("FAIL late_ready got rd=%b st=%b want 0/0", bus.mem_read, bus.proc_stall);
    end
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    access(30'h0000024, 3, {$urandom, $urandom, $urandom, $urandom});
    total++;
    if (m_misses !== 1) begin
      bad++;
      $display("FAIL rst_refetch_miss got=%0d want=1", m_misses);
    end
  endtask

  task automatic test_random();
    logic [29:0] addr;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.proc_read = 1'b0;
        bus.proc_addr = 30'($urandom);
        bus.mem_ready = 1'($urandom_range(0, 1));
        bus.mem_rdata = {4{$urandom}};
        @(negedge clk);
        total++;
        if (bus.proc_stall !== 1'b0 || bus.proc_rdata !== 32'h0 || bus.mem_read !== 1'b0 ||
            bus.mem_write !== 1'b0 || bus.mem_wdata !== 128'h0) begin
          bad++;
          $display("FAIL rand_idle i=%0d got st=%b d=%h rd=%b mw=%b want 0/0/0/0",
                   i, bus.proc_stall, bus.proc_rdata, bus.mem_read, bus.mem_write);
        end
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
      end else begin
        addr = ($urandom_range(0, 7) == 0) ? 30'($urandom) : 30'($urandom_range(0, 127));
        access(addr, $urandom_range(1, 6), {$urandom, $urandom, $urandom, $urandom});
      end
    end
  endtask

  initial begin
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
    bus.proc_addr  = '0;
    bus.proc_wdata = '0;
    bus.mem_ready  = 1'b0;
    bus.mem_rdata  = '0;
    test_reset();
    test_cold_and_hit();
    test_conflict();
`ifdef ICACHE_PERF_EN
    test_perf(3);
`endif
    test_addr_change();
    test_reset_mid_fetch();
    test_random();
`ifdef ICACHE_PERF_EN
    test_perf(m_misses);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
